// File: rtl/spi_master_byte.sv
// Byte-level SPI master shift engine (CPHA=0, MSB first). Half-periods of SCK
// advance only on ena_2clk ticks; slave select is owned by the upstream controller.
module spi_master_byte #(
  parameter int DW   = 8,
  parameter bit CPOL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena_2clk,
  input  logic          send,
  input  logic [DW-1:0] data_in,
  input  logic          miso,
  output logic          sck,
  output logic          mosi,
  output logic          busy,
  output logic [DW-1:0] data_out,
  output logic          data_valid
);

  localparam int            HW    = $clog2(2 * DW);
  localparam logic [HW-1:0] HLAST = HW'(2 * DW - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT} state_t;

  state_t        state;
  logic [DW-1:0] tx_sr;
  logic [DW-1:0] rx_sr;
  logic [HW-1:0] hcnt;

  // NOTE: every register here uses non-blocking assignments so all updates on
  // an edge see the pre-edge values; blocking here would chain shifts in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      hcnt       <= '0;
      sck        <= CPOL;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A tick arriving with the accepted send is deliberately not consumed.
          if (send) begin
            tx_sr <= data_in;
            mosi  <= data_in[DW-1];
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          // One full half-period of MOSI setup before the first leading edge.
          if (ena_2clk) begin
            hcnt  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ena_2clk) begin
            if (!hcnt[0]) begin
              sck   <= ~CPOL;
              rx_sr <= {rx_sr[DW-2:0], miso};
              hcnt  <= hcnt + 1'b1;
            end else if (hcnt != HLAST) begin
              sck   <= CPOL;
              tx_sr <= {tx_sr[DW-2:0], 1'b0};
              mosi  <= tx_sr[DW-2];
              hcnt  <= hcnt + 1'b1;
            end else begin
              // Last MISO bit was already captured on the preceding leading edge.
              sck        <= CPOL;
              mosi       <= 1'b0;
              busy       <= 1'b0;
              data_out   <= rx_sr;
              data_valid <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: one CPOL=0 and one CPOL=1 instance,
// with a single stepping task that drives ticks and tracks edges at negedge.
module tb_spi_master_byte;

  localparam logic [1:0] CPOLS = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            ena_2clk;
  logic [1:0]      send, miso, sck, mosi, busy, data_valid;
  logic [1:0]      loop_mode, miso_const;
  logic [1:0][7:0] data_in;
  logic [1:0][7:0] data_out;

  assign miso = (loop_mode & mosi) | (~loop_mode & miso_const);

  spi_master_byte #(.DW(8), .CPOL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ena_2clk(ena_2clk), .send(send[0]),
    .data_in(data_in[0]), .miso(miso[0]), .sck(sck[0]), .mosi(mosi[0]),
    .busy(busy[0]), .data_out(data_out[0]), .data_valid(data_valid[0])
  );

  spi_master_byte #(.DW(8), .CPOL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena_2clk(ena_2clk), .send(send[1]),
    .data_in(data_in[1]), .miso(miso[1]), .sck(sck[1]), .mosi(mosi[1]),
    .busy(busy[1]), .data_out(data_out[1]), .data_valid(data_valid[1])
  );

  int         checks = 0;
  int         errors = 0;
  int         lead_cnt [2];
  int         ticks_busy [2];
  int         dv_cnt [2];
  logic [7:0] mosi_bits [2];
  logic       mosi_hi [2];
  logic [1:0] prev_sck, prev_busy;
  int         tick_cnt;
  bit         tick_on;
  logic [7:0] rx_log [16];
  int         rx_n;

  // Advance to the next negedge, account for the posedge just passed, then
  // drive ena_2clk for the coming posedge (one tick every 12 clocks).
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (prev_sck[i] === CPOLS[i] && sck[i] === ~CPOLS[i]) begin
        lead_cnt[i]++;
        mosi_bits[i] = {mosi_bits[i][6:0], mosi[i]};
      end
      if (busy[i] === 1'b1 && mosi[i] === 1'b1) mosi_hi[i] = 1'b1;
      if (ena_2clk === 1'b1 && prev_busy[i] === 1'b1) ticks_busy[i]++;
      if (data_valid[i] === 1'b1) begin
        dv_cnt[i]++;
        if (i == 0 && rx_n < 16) begin
          rx_log[rx_n] = data_out[0];
          rx_n++;
        end
      end
    end
    prev_sck  = sck;
    prev_busy = busy;
    if (tick_cnt == 11) tick_cnt = 0;
    else tick_cnt++;
    ena_2clk = tick_on && (tick_cnt == 0);
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      lead_cnt[i]   = 0;
      ticks_busy[i] = 0;
      dv_cnt[i]     = 0;
      mosi_bits[i]  = 8'h00;
      mosi_hi[i]    = 1'b0;
    end
  endtask

  // align: 0 = send off-tick, 1 = send on a tick, 2 = send immediately
  task automatic start(input int i, input logic [7:0] d, input int align);
    clear_mon();
    if (align != 2) begin
      for (int n = 0; n < 30 && ena_2clk !== align[0]; n++) step();
      checks++;
      if (ena_2clk !== align[0]) begin
        errors++;
        $display("FAIL tick_align: ena_2clk=%b wanted %b", ena_2clk, align[0]);
      end
    end
    send[i]    = 1'b1;
    data_in[i] = d;
    step();
    send[i]    = 1'b0;
    checks++;
    if (busy[i] !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise[%0d]: busy=%b expected 1", i, busy[i]);
    end
    step();
    checks++;
    if (busy[i] !== 1'b1) begin
      errors++;
      $display("FAIL busy_recheck[%0d]: busy=%b expected 1", i, busy[i]);
    end
  endtask

  task automatic finish_xfer(input int i);
    for (int n = 0; n < 1000 && busy[i] === 1'b1; n++) step();
    checks++;
    if (busy[i] !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout[%0d]: busy=%b expected 0", i, busy[i]);
    end
  endtask

  task automatic wait_ticks(input int i, input int t);
    for (int n = 0; n < 1000 && ticks_busy[i] < t; n++) step();
    checks++;
    if (ticks_busy[i] != t) begin
      errors++;
      $display("FAIL wait_ticks[%0d]: ticks=%0d expected %0d", i, ticks_busy[i], t);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (sck !== 2'b10 || mosi !== 2'b00 || busy !== 2'b00 || data_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: sck=%b mosi=%b busy=%b dv=%b expected 10 00 00 00",
               sck, mosi, busy, data_valid);
    end
    checks++;
    if (data_out[0] !== 8'h00 || data_out[1] !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: data_out=%h/%h expected 00/00", data_out[0], data_out[1]);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_loopback();
    loop_mode = 2'b01;
    start(0, 8'hA5, 0);
    finish_xfer(0);
    repeat (3) step();
    checks++;
    if (lead_cnt[0] != 8) begin
      errors++;
      $display("FAIL lb_edges: got %0d expected 8", lead_cnt[0]);
    end
    checks++;
    if (mosi_bits[0] !== 8'hA5) begin
      errors++;
      $display("FAIL lb_mosi_bits: got %h expected a5", mosi_bits[0]);
    end
    checks++;
    if (dv_cnt[0] != 1) begin
      errors++;
      $display("FAIL lb_valid_pulse: got %0d cycles expected 1", dv_cnt[0]);
    end
    checks++;
    if (data_out[0] !== 8'hA5) begin
      errors++;
      $display("FAIL lb_data: got %h expected a5", data_out[0]);
    end
    checks++;
    if (ticks_busy[0] != 17) begin
      errors++;
      $display("FAIL lb_ticks: got %0d expected 17", ticks_busy[0]);
    end
    checks++;
    if (sck[0] !== 1'b0 || mosi[0] !== 1'b0) begin
      errors++;
      $display("FAIL lb_idle: sck=%b mosi=%b expected 0 0", sck[0], mosi[0]);
    end
  endtask

  task automatic test_const_miso();
    loop_mode  = 2'b00;
    miso_const = 2'b11;
    start(0, 8'h00, 0);
    finish_xfer(0);
    checks++;
    if (mosi_hi[0] !== 1'b0) begin
      errors++;
      $display("FAIL const_mosi_low: saw mosi=1 expected none");
    end
    checks++;
    if (data_out[0] !== 8'hFF) begin
      errors++;
      $display("FAIL const_miso1: got %h expected ff", data_out[0]);
    end
    miso_const = 2'b00;
    start(0, 8'hFF, 0);
    finish_xfer(0);
    checks++;
    if (data_out[0] !== 8'h00) begin
      errors++;
      $display("FAIL const_miso0: got %h expected 00", data_out[0]);
    end
    checks++;
    if (mosi_bits[0] !== 8'hFF) begin
      errors++;
      $display("FAIL const_mosi_ff: got %h expected ff", mosi_bits[0]);
    end
  endtask

  task automatic test_ignored();
    loop_mode = 2'b01;
    start(0, 8'h3C, 0);
    wait_ticks(0, 5);
    send[0]    = 1'b1;
    data_in[0] = 8'hFF;
    step();
    send[0]    = 1'b0;
    data_in[0] = 8'h00;
    finish_xfer(0);
    repeat (4) step();
    checks++;
    if (data_out[0] !== 8'h3C) begin
      errors++;
      $display("FAIL ign_data: got %h expected 3c", data_out[0]);
    end
    checks++;
    if (dv_cnt[0] != 1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ign_single: dv=%0d busy=%b expected 1 0", dv_cnt[0], busy[0]);
    end
    checks++;
    if (ticks_busy[0] != 17) begin
      errors++;
      $display("FAIL ign_ticks: got %0d expected 17", ticks_busy[0]);
    end
  endtask

  task automatic test_coincident();
    loop_mode = 2'b01;
    start(0, 8'h96, 1);
    finish_xfer(0);
    checks++;
    if (ticks_busy[0] != 17) begin
      errors++;
      $display("FAIL coin_ticks: got %0d expected 17", ticks_busy[0]);
    end
    checks++;
    if (data_out[0] !== 8'h96 || lead_cnt[0] != 8) begin
      errors++;
      $display("FAIL coin_data: got %h/%0d expected 96/8", data_out[0], lead_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    loop_mode = 2'b01;
    start(0, 8'hC3, 0);
    wait_ticks(0, 9);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (sck[0] !== 1'b0 || mosi[0] !== 1'b0 || busy[0] !== 1'b0 || data_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ctrl: sck=%b mosi=%b busy=%b dv=%b expected 0 0 0 0",
               sck[0], mosi[0], busy[0], data_valid[0]);
    end
    checks++;
    if (data_out[0] !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_data: got %h expected 00", data_out[0]);
    end
    step();
    start(0, 8'h81, 0);
    finish_xfer(0);
    checks++;
    if (data_out[0] !== 8'h81 || lead_cnt[0] != 8) begin
      errors++;
      $display("FAIL rstmid_resume: got %h/%0d expected 81/8", data_out[0], lead_cnt[0]);
    end
  endtask

  task automatic test_cpol1();
    checks++;
    if (sck[1] !== 1'b1) begin
      errors++;
      $display("FAIL cpol1_idle: sck=%b expected 1", sck[1]);
    end
    loop_mode = 2'b10;
    start(1, 8'h5A, 0);
    finish_xfer(1);
    step();
    checks++;
    if (lead_cnt[1] != 8 || mosi_bits[1] !== 8'h5A) begin
      errors++;
      $display("FAIL cpol1_edges: got %0d/%h expected 8/5a", lead_cnt[1], mosi_bits[1]);
    end
    checks++;
    if (data_out[1] !== 8'h5A || sck[1] !== 1'b1) begin
      errors++;
      $display("FAIL cpol1_data: got %h sck=%b expected 5a 1", data_out[1], sck[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5];
    seq = '{8'h08, 8'h0E, 8'h03, 8'h03, 8'hE8};
    loop_mode = 2'b01;
    rx_n = 0;
    for (int k = 0; k < 5; k++) begin
      start(0, seq[k], 2);
      finish_xfer(0);
    end
    repeat (3) step();
    checks++;
    if (rx_n != 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 5", rx_n);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rx_log[k] !== seq[k]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h expected %h", k, rx_log[k], seq[k]);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ena_2clk   = 1'b0;
    send       = 2'b00;
    data_in    = '0;
    loop_mode  = 2'b00;
    miso_const = 2'b00;
    tick_on    = 1'b1;
    tick_cnt   = 0;
    prev_sck   = 2'b10;
    prev_busy  = 2'b00;
    rx_n       = 0;
    clear_mon();

    test_reset();
    test_loopback();
    test_const_miso();
    test_ignored();
    test_coincident();
    test_reset_mid();
    test_cpol1();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
